// File: rtl/delay_corr_window_sum.sv
// Sliding-window complex accumulator: running sum of the last WIN accepted
// correlation products, one-cycle latency, synchronous flush via Clear.
module delay_corr_window_sum #(
  parameter int WIN = 16,
  parameter int DW  = 16,
  parameter int SW  = 20
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          InputEnable,
  input  logic [DW-1:0] DataInRe,
  input  logic [DW-1:0] DataInIm,
  input  logic          Clear,
  output logic          OutputEnable,
  output logic [SW-1:0] DataOutRe,
  output logic [SW-1:0] DataOutIm,
  output logic          WindowFull
);

  localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int FW = $clog2(WIN + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(WIN - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIN);

  function automatic logic [SW-1:0] sext(input logic [DW-1:0] x);
    return {{(SW-DW){x[DW-1]}}, x};
  endfunction

  logic [DW-1:0] mem_re_q [WIN];
  logic [DW-1:0] mem_im_q [WIN];

  logic [PW-1:0] wp_q, wp_d, widx;
  logic [FW-1:0] fill_q, fill_d;
  logic [SW-1:0] sum_re_q, sum_re_d, sum_im_q, sum_im_d;
  logic [SW-1:0] base_re, base_im, old_re, old_im;
  logic          oe_q, oe_d, full_q, full_d;
  logic [SW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;

  // Clear with a sample present restarts the window at slot 0 holding only that sample.
  always_comb begin
    wp_d     = wp_q;
    fill_d   = fill_q;
    sum_re_d = sum_re_q;
    sum_im_d = sum_im_q;
    full_d   = full_q;
    oe_d     = 1'b0;
    out_re_d = '0;
    out_im_d = '0;
    widx     = Clear ? '0 : wp_q;
    base_re  = Clear ? '0 : sum_re_q;
    base_im  = Clear ? '0 : sum_im_q;
    old_re   = '0;
    old_im   = '0;
    if (!Clear && fill_q == FILL_MAX) begin
      old_re = sext(mem_re_q[wp_q]);
      old_im = sext(mem_im_q[wp_q]);
    end
    if (Clear) begin
      wp_d     = '0;
      fill_d   = '0;
      sum_re_d = '0;
      sum_im_d = '0;
      full_d   = 1'b0;
    end
    if (InputEnable) begin
      sum_re_d = base_re + sext(DataInRe) - old_re;
      sum_im_d = base_im + sext(DataInIm) - old_im;
      wp_d     = (widx == PTR_LAST) ? '0 : widx + PW'(1);
      if (Clear)
        fill_d = FW'(1);
      else if (fill_q != FILL_MAX)
        fill_d = fill_q + FW'(1);
      full_d   = (fill_d == FILL_MAX);
      oe_d     = 1'b1;
      out_re_d = sum_re_d;
      out_im_d = sum_im_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wp_q     <= '0;
      fill_q   <= '0;
      sum_re_q <= '0;
      sum_im_q <= '0;
      full_q   <= 1'b0;
      oe_q     <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      wp_q     <= wp_d;
      fill_q   <= fill_d;
      sum_re_q <= sum_re_d;
      sum_im_q <= sum_im_d;
      full_q   <= full_d;
      oe_q     <= oe_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

  // Sample storage needs no reset: stale entries are masked until the fill count saturates.
  always_ff @(posedge Clk) begin
    if (InputEnable) begin
      mem_re_q[widx] <= DataInRe;
      mem_im_q[widx] <= DataInIm;
    end
  end

  assign OutputEnable = oe_q;
  assign DataOutRe    = out_re_q;
  assign DataOutIm    = out_im_q;
  assign WindowFull   = full_q;

endmodule
